// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 channel multiplexer.
package mux_pkg;

  localparam int unsigned NCH_DEFAULT = 8;
  localparam int unsigned W_DEFAULT   = 8;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter  int unsigned NCH = 8,
  localparam int unsigned SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output logic [SW-1:0]  idx
);

  int unsigned k;
  logic        found;

  // Scan ptr+1 .. ptr+NCH so the last-granted channel has lowest priority.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      k = (32'(ptr) + i) % NCH;
      if (en && !found && req[SW'(k)]) begin
        found          = 1'b1;
        gnt[SW'(k)]    = 1'b1;
        idx            = SW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_seq.sv
// Registered N-to-1 channel mux with manual or round-robin selection and valid/ready output.
// Optional out_par port is enabled by defining MUX_NX1_SEQ_PARITY_EN.
module mux_nx1_seq
  import mux_pkg::*;
#(
  parameter  int unsigned NCH = NCH_DEFAULT,
  parameter  int unsigned W   = W_DEFAULT,
  localparam int unsigned SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_NX1_SEQ_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic           slot_free;
  logic           scan_en;
  logic           man_hit;
  logic           grant;
  logic [NCH-1:0] rr_gnt;
  logic [NCH-1:0] man_gnt;
  logic [SW-1:0]  rr_idx;
  logic [SW-1:0]  gnt_idx;
  logic [SW-1:0]  ptr;
  logic [W-1:0]   gnt_word;

  // Reset gates the grant so no channel is strobed while rst is high.
  assign slot_free = !rst && (!out_valid || out_ready);
  assign scan_en   = slot_free && (mode == MODE_SCAN);
  assign man_hit   = slot_free && (mode == MODE_MANUAL) && (32'(sel) < NCH) && in_valid[sel];
  assign man_gnt   = man_hit ? (NCH'(1) << sel) : '0;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req (in_valid),
    .ptr (ptr),
    .en  (scan_en),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign in_ready = scan_en ? rr_gnt : man_gnt;
  assign grant    = |in_ready;
  assign gnt_idx  = scan_en ? rr_idx : sel;

  // One-hot AND-OR data select.
  always_comb begin
    gnt_word = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (in_ready[c]) gnt_word = gnt_word | in_data[c*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= SW'(NCH - 1);
    end else if (slot_free) begin
      if (grant) begin
        out_data  <= gnt_word;
        out_chan  <= gnt_idx;
        out_valid <= 1'b1;
        if (scan_en) ptr <= rr_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_NX1_SEQ_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (slot_free && grant) begin
      out_par <= ^gnt_word;
    end
  end
`endif

endmodule
